bcd_time_counter: RTL and testbench

BCD_TIME_COUNTER -- requirements
Module: bcd_time_counter

---
 rtl/bcd_time_counter.sv | 160 ++++++++++++++++
 tb/tb_bcd_time_counter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_time_counter.sv
// BCD mm:ss counter with enable prescaler, up/down counting, validated preset and wrap pulse.
// Optional macro BCD_TIME_COUNTER_SATURATE_EN: hold at the limits instead of wrapping.
module bcd_time_counter #(
  parameter int MIN_MAX  = 59,
  parameter int TICK_DIV = 1
) (
  input  logic       CLK1,
  input  logic       RESET,
  input  logic       enable,
  input  logic       up_down,
  input  logic       load,
  input  logic [3:0] load_min10,
  input  logic [3:0] load_min01,
  input  logic [3:0] load_sec10,
  input  logic [3:0] load_sec01,
  output logic [3:0] min10,
  output logic [3:0] min01,
  output logic [3:0] sec10,
  output logic [3:0] sec01,
  output logic       wrap,
  output logic       load_err,
  output logic       is_zero
);

  localparam int              PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [3:0]      MAX10    = 4'(MIN_MAX / 10);
  localparam logic [3:0]      MAX01    = 4'(MIN_MAX % 10);

  logic [3:0]    r_min10, r_min01, r_sec10, r_sec01;
  logic [PW-1:0] r_pre;
  logic          r_wrap, r_load_err, r_is_zero;

  logic          w_load_ok, w_tick, w_at_max, w_at_zero, w_lim;
  logic [PW-1:0] w_pre_nxt;
  logic [3:0]    w_min10_s, w_min01_s, w_sec10_s, w_sec01_s;

  // Digits are valid BCD, so a lexicographic compare of the minute pair is a numeric compare.
  assign w_load_ok = (load_min10 <= 4'd9) && (load_min01 <= 4'd9) &&
                     (load_sec10 <= 4'd5) && (load_sec01 <= 4'd9) &&
                     ({load_min10, load_min01} <= {MAX10, MAX01});

  assign w_tick    = enable && (r_pre == PRE_LAST);
  assign w_pre_nxt = !enable ? r_pre : (w_tick ? '0 : r_pre + PW'(1));

  assign w_at_max  = (r_min10 == MAX10) && (r_min01 == MAX01) &&
                     (r_sec10 == 4'd5) && (r_sec01 == 4'd9);
  assign w_at_zero = (r_min10 == 4'd0) && (r_min01 == 4'd0) &&
                     (r_sec10 == 4'd0) && (r_sec01 == 4'd0);
  assign w_lim     = up_down ? w_at_max : w_at_zero;

  // One-second step in the selected direction, including the limit case.
  always_comb begin
    w_min10_s = r_min10;
    w_min01_s = r_min01;
    w_sec10_s = r_sec10;
    w_sec01_s = r_sec01;
    if (up_down) begin
      if (w_at_max) begin
`ifdef BCD_TIME_COUNTER_SATURATE_EN
        w_sec01_s = r_sec01;
`else
        w_min10_s = 4'd0;
        w_min01_s = 4'd0;
        w_sec10_s = 4'd0;
        w_sec01_s = 4'd0;
`endif
      end else if (r_sec01 != 4'd9) begin
        w_sec01_s = r_sec01 + 4'd1;
      end else begin
        w_sec01_s = 4'd0;
        if (r_sec10 != 4'd5) begin
          w_sec10_s = r_sec10 + 4'd1;
        end else begin
          w_sec10_s = 4'd0;
          if (r_min01 != 4'd9) begin
            w_min01_s = r_min01 + 4'd1;
          end else begin
            w_min01_s = 4'd0;
            w_min10_s = r_min10 + 4'd1;
          end
        end
      end
    end else begin
      if (w_at_zero) begin
`ifdef BCD_TIME_COUNTER_SATURATE_EN
        w_sec01_s = r_sec01;
`else
        w_min10_s = MAX10;
        w_min01_s = MAX01;
        w_sec10_s = 4'd5;
        w_sec01_s = 4'd9;
`endif
      end else if (r_sec01 != 4'd0) begin
        w_sec01_s = r_sec01 - 4'd1;
      end else begin
        w_sec01_s = 4'd9;
        if (r_sec10 != 4'd0) begin
          w_sec10_s = r_sec10 - 4'd1;
        end else begin
          w_sec10_s = 4'd5;
          if (r_min01 != 4'd0) begin
            w_min01_s = r_min01 - 4'd1;
          end else begin
            w_min01_s = 4'd9;
            w_min10_s = r_min10 - 4'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge CLK1) begin
    if (RESET) begin
      r_min10    <= 4'd0;
      r_min01    <= 4'd0;
      r_sec10    <= 4'd0;
      r_sec01    <= 4'd0;
      r_pre      <= '0;
      r_wrap     <= 1'b0;
      r_load_err <= 1'b0;
      r_is_zero  <= 1'b1;
    end else begin
      r_wrap     <= 1'b0;
      r_load_err <= 1'b0;
      if (load) begin
        // A rejected load leaves both time and prescaler untouched.
        if (w_load_ok) begin
          r_min10   <= load_min10;
          r_min01   <= load_min01;
          r_sec10   <= load_sec10;
          r_sec01   <= load_sec01;
          r_pre     <= '0;
          r_is_zero <= ({load_min10, load_min01, load_sec10, load_sec01} == 16'h0000);
        end else begin
          r_load_err <= 1'b1;
        end
      end else begin
        r_pre <= w_pre_nxt;
        if (w_tick) begin
          r_min10   <= w_min10_s;
          r_min01   <= w_min01_s;
          r_sec10   <= w_sec10_s;
          r_sec01   <= w_sec01_s;
          r_wrap    <= w_lim;
          r_is_zero <= ({w_min10_s, w_min01_s, w_sec10_s, w_sec01_s} == 16'h0000);
        end
      end
    end
  end

  assign min10    = r_min10;
  assign min01    = r_min01;
  assign sec10    = r_sec10;
  assign sec01    = r_sec01;
  assign wrap     = r_wrap;
  assign load_err = r_load_err;
  assign is_zero  = r_is_zero;

endmodule

// File: tb/tb_bcd_time_counter.sv
// Directed bench: three instances (59/1, 59/4, 23/1) share stimulus; each task checks the relevant one.
module tb_bcd_time_counter;

`ifdef BCD_TIME_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       CLK1, RESET, enable, up_down, load;
  logic [3:0] ld_m10, ld_m01, ld_s10, ld_s01;
  wire  [15:0] ta, tb4, tc;
  wire        wa, ea, za, wb, eb, zb, wc, ec, zc;
  int         chk, err, nw, nwb;

  bcd_time_counter #(.MIN_MAX(59), .TICK_DIV(1)) u_a (
    .CLK1(CLK1), .RESET(RESET), .enable(enable), .up_down(up_down), .load(load),
    .load_min10(ld_m10), .load_min01(ld_m01), .load_sec10(ld_s10), .load_sec01(ld_s01),
    .min10(ta[15:12]), .min01(ta[11:8]), .sec10(ta[7:4]), .sec01(ta[3:0]),
    .wrap(wa), .load_err(ea), .is_zero(za));

  bcd_time_counter #(.MIN_MAX(59), .TICK_DIV(4)) u_b (
    .CLK1(CLK1), .RESET(RESET), .enable(enable), .up_down(up_down), .load(load),
    .load_min10(ld_m10), .load_min01(ld_m01), .load_sec10(ld_s10), .load_sec01(ld_s01),
    .min10(tb4[15:12]), .min01(tb4[11:8]), .sec10(tb4[7:4]), .sec01(tb4[3:0]),
    .wrap(wb), .load_err(eb), .is_zero(zb));

  bcd_time_counter #(.MIN_MAX(23), .TICK_DIV(1)) u_c (
    .CLK1(CLK1), .RESET(RESET), .enable(enable), .up_down(up_down), .load(load),
    .load_min10(ld_m10), .load_min01(ld_m01), .load_sec10(ld_s10), .load_sec01(ld_s01),
    .min10(tc[15:12]), .min01(tc[11:8]), .sec10(tc[7:4]), .sec01(tc[3:0]),
    .wrap(wc), .load_err(ec), .is_zero(zc));

  initial CLK1 = 1'b0;
  always #5 CLK1 = ~CLK1;

  task automatic cyc();
    @(posedge CLK1);
    #1;
  endtask

  task automatic set_ld(input logic [15:0] v);
    {ld_m10, ld_m01, ld_s10, ld_s01} = v;
  endtask

  task automatic test_reset();
    RESET = 1'b1; load = 1'b0; enable = 1'b0; up_down = 1'b1; set_ld(16'h0000);
    cyc(); cyc();
    RESET = 1'b0;
    chk++; if (ta !== 16'h0000) begin err++; $display("FAIL reset_digits: got %h want %h", ta, 16'h0000); end
    chk++; if ({za, wa, ea} !== 3'b100) begin err++; $display("FAIL reset_flags: got %b want %b", {za, wa, ea}, 3'b100); end
    chk++; if (tc !== 16'h0000 || zc !== 1'b1) begin err++; $display("FAIL reset_m23: got %h/%b want 0000/1", tc, zc); end
  endtask

  task automatic test_full_hour();
    logic [15:0] exp_a, exp_c;
    nw = 0; nwb = 0;
    enable = 1'b1; up_down = 1'b1;
    for (int i = 1; i <= 3600; i++) begin
      cyc();
      nw += int'(wa);
      nwb += int'(wb);
      if (i == 1) begin
        chk++; if (ta !== 16'h0001 || za !== 1'b0) begin err++; $display("FAIL full_first: got %h/%b want 0001/0", ta, za); end
      end
      if (i == 60) begin
        chk++; if (ta !== 16'h0100) begin err++; $display("FAIL full_min_carry: got %h want %h", ta, 16'h0100); end
      end
      if (i == 3599) begin
        chk++; if (ta !== 16'h5959 || nw != 0) begin err++; $display("FAIL full_5959: got %h wraps %0d want 5959 wraps 0", ta, nw); end
      end
    end
    exp_a = SAT ? 16'h5959 : 16'h0000;
    exp_c = SAT ? 16'h2359 : 16'h1200;
    chk++; if (ta !== exp_a || wa !== 1'b1 || za !== !SAT) begin err++; $display("FAIL full_wrap: got %h w%b z%b want %h w1 z%b", ta, wa, za, exp_a, !SAT); end
    chk++; if (nw != 1) begin err++; $display("FAIL full_wrap_count: got %0d want 1", nw); end
    chk++; if (tb4 !== 16'h1500 || nwb != 0) begin err++; $display("FAIL full_div4: got %h wraps %0d want 1500 wraps 0", tb4, nwb); end
    chk++; if (tc !== exp_c) begin err++; $display("FAIL full_m23: got %h want %h", tc, exp_c); end
    enable = 1'b0;
    cyc();
    chk++; if (wa !== 1'b0 || ta !== exp_a) begin err++; $display("FAIL full_hold: got %h w%b want %h w0", ta, wa, exp_a); end
  endtask

  task automatic test_load_carry();
    load = 1'b1; set_ld(16'h0959); enable = 1'b1; up_down = 1'b1;
    cyc();
    chk++; if (ta !== 16'h0959 || ea !== 1'b0) begin err++; $display("FAIL load_0959: got %h e%b want 0959 e0", ta, ea); end
    load = 1'b0;
    cyc();
    chk++; if (ta !== 16'h1000) begin err++; $display("FAIL carry_up: got %h want %h", ta, 16'h1000); end
    up_down = 1'b0;
    cyc();
    chk++; if (ta !== 16'h0959) begin err++; $display("FAIL borrow_down: got %h want %h", ta, 16'h0959); end
    enable = 1'b0;
  endtask

  task automatic test_load_err();
    load = 1'b1; set_ld(16'h0960); enable = 1'b1;
    cyc();
    chk++; if (ta !== 16'h0959 || ea !== 1'b1) begin err++; $display("FAIL err_sec10: got %h e%b want 0959 e1", ta, ea); end
    load = 1'b0; enable = 1'b0;
    cyc();
    chk++; if (ta !== 16'h0959 || ea !== 1'b0) begin err++; $display("FAIL err_clear: got %h e%b want 0959 e0", ta, ea); end
    load = 1'b1; set_ld(16'h6000); enable = 1'b1;
    cyc();
    chk++; if (ta !== 16'h0959 || ea !== 1'b1 || ec !== 1'b1) begin err++; $display("FAIL err_min60: got %h e%b ec%b want 0959 e1 ec1", ta, ea, ec); end
    set_ld(16'h5959);
    cyc();
    chk++; if (ta !== 16'h5959 || ea !== 1'b0 || ec !== 1'b1) begin err++; $display("FAIL load_5959: got %h e%b ec%b want 5959 e0 ec1", ta, ea, ec); end
    set_ld(16'h2359);
    cyc();
    chk++; if (tc !== 16'h2359 || ec !== 1'b0) begin err++; $display("FAIL load_m23_max: got %h ec%b want 2359 ec0", tc, ec); end
    set_ld(16'h000a);
    cyc();
    chk++; if (ta !== 16'h2359 || ea !== 1'b1) begin err++; $display("FAIL err_sec01: got %h e%b want 2359 e1", ta, ea); end
    load = 1'b0; enable = 1'b0;
  endtask

  task automatic test_prescale();
    logic        en_seq [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [15:0] exp_seq[5] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0001};
    load = 1'b1; set_ld(16'h0000); up_down = 1'b1;
    cyc();
    load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      enable = en_seq[i];
      cyc();
      chk++; if (tb4 !== exp_seq[i]) begin err++; $display("FAIL prescale_%0d: got %h want %h", i, tb4, exp_seq[i]); end
    end
    chk++; if (ta !== 16'h0004) begin err++; $display("FAIL prescale_div1: got %h want %h", ta, 16'h0004); end
    enable = 1'b0;
  endtask

  task automatic test_down_zero();
    logic [15:0] exp_c, exp_a;
    load = 1'b1; set_ld(16'h0001); up_down = 1'b0;
    cyc();
    load = 1'b0; enable = 1'b1;
    cyc();
    chk++; if (tc !== 16'h0000 || zc !== 1'b1 || wc !== 1'b0) begin err++; $display("FAIL down_zero: got %h z%b w%b want 0000 z1 w0", tc, zc, wc); end
    cyc();
    exp_c = SAT ? 16'h0000 : 16'h2359;
    chk++; if (tc !== exp_c || wc !== 1'b1 || zc !== SAT) begin err++; $display("FAIL down_wrap: got %h w%b z%b want %h w1 z%b", tc, wc, zc, exp_c, SAT); end
    enable = 1'b0;
    cyc();
    chk++; if (wc !== 1'b0) begin err++; $display("FAIL down_wrap_clear: got %b want 0", wc); end
    load = 1'b1; set_ld(16'h5959); up_down = 1'b1;
    cyc();
    load = 1'b0; enable = 1'b1;
    cyc();
    exp_a = SAT ? 16'h5959 : 16'h0000;
    chk++; if (ta !== exp_a || wa !== 1'b1) begin err++; $display("FAIL up_limit: got %h w%b want %h w1", ta, wa, exp_a); end
    enable = 1'b0;
  endtask

  task automatic test_reset_override();
    load = 1'b1; set_ld(16'h1234); enable = 1'b0;
    cyc();
    chk++; if (ta !== 16'h1234 || za !== 1'b0) begin err++; $display("FAIL preload_1234: got %h z%b want 1234 z0", ta, za); end
    set_ld(16'h4500); enable = 1'b1; RESET = 1'b1;
    cyc();
    chk++; if (ta !== 16'h0000 || {za, wa, ea} !== 3'b100) begin err++; $display("FAIL reset_over_load: got %h %b want 0000 100", ta, {za, wa, ea}); end
    set_ld(16'h0060);
    cyc();
    chk++; if (ea !== 1'b0 || ta !== 16'h0000) begin err++; $display("FAIL reset_over_bad_load: got %h e%b want 0000 e0", ta, ea); end
    RESET = 1'b0; load = 1'b0; enable = 1'b1;
    cyc(); cyc();
    RESET = 1'b1;
    cyc();
    RESET = 1'b0;
    cyc(); cyc(); cyc();
    chk++; if (tb4 !== 16'h0000) begin err++; $display("FAIL reset_mid_prescale: got %h want %h", tb4, 16'h0000); end
    cyc();
    chk++; if (tb4 !== 16'h0001) begin err++; $display("FAIL prescale_after_reset: got %h want %h", tb4, 16'h0001); end
    enable = 1'b0;
  endtask

  initial begin
    chk = 0; err = 0;
    test_reset();
    test_full_hour();
    test_load_carry();
    test_load_err();
    test_prescale();
    test_down_zero();
    test_reset_override();
    $display("Simulation finished: %0d checks, %0d errors", chk, err);
    $finish;
  end

endmodule
